// File: rtl/clock_set_controller.sv
// Front-panel controller for the 7-segment clock: debounces the mode/up buttons,
// sequences RUN -> SET_HRS -> SET_MINS, and drives increment pulses, pause and blink mask.
module clock_set_controller #(
    parameter int DEBOUNCE_CYC      = 1_000_000,
    parameter int REPEAT_DELAY_CYC  = 50_000_000,
    parameter int REPEAT_PERIOD_CYC = 20_000_000,
    parameter int BLINK_HALF_CYC    = 25_000_000,
    parameter int TIMEOUT_CYC       = 1_000_000_000
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       inc_hrs,
    output logic       inc_mins,
    output logic       clk_pause,
    output logic [1:0] mode,
    output logic [3:0] digit_blank
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int BLINK_W  = $clog2(BLINK_HALF_CYC + 1);
    localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0]  DELAY_LAST = HOLD_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [HOLD_W-1:0]  RPT_LAST   = HOLD_W'(REPEAT_PERIOD_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYC - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HRS  = 2'd1,
        SET_MINS = 2'd2
    } state_t;

    // Button index 0 = mode, 1 = up.
    logic [1:0]      raw, sync1, sync2, db, press;
    logic [DB_W-1:0] db_cnt [2];

    assign raw = {btn_up, btn_mode};

    always_ff @(posedge clk_100Mhz or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync2 take the old sync1, forming a real 2-FF chain.
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic mode_press, up_press, up_level;
    assign mode_press = press[0];
    assign up_press   = press[1];
    assign up_level   = db[1];

    state_t             state, state_nxt;
    logic               phase, phase_nxt, armed, repeating;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               in_set, up_accept, rpt_fire, timed_out, pulse, entering;
    logic [3:0]         blank_nxt;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        in_set    = (state != RUN);
        up_accept = in_set && up_press && !mode_press;
        rpt_fire  = armed && up_level && !mode_press &&
                    (repeating ? (hold_cnt == RPT_LAST) : (hold_cnt == DELAY_LAST));
        timed_out = in_set && !mode_press && !up_accept && !rpt_fire && (to_cnt == TO_LAST);
        pulse     = up_accept || rpt_fire;

        if (mode_press) begin
            unique case (state)
                RUN:     state_nxt = SET_HRS;
                SET_HRS: state_nxt = SET_MINS;
                default: state_nxt = RUN;
            endcase
        end else if (timed_out) begin
            state_nxt = RUN;
        end
        entering = (state_nxt != state) && (state_nxt != RUN);

        // The edited field is forced visible on entry and after every change.
        if (state_nxt == RUN || entering || pulse) phase_nxt = 1'b0;
        else if (blink_cnt == BLINK_LAST)          phase_nxt = ~phase;
        else                                       phase_nxt = phase;

        unique case (state_nxt)
            SET_HRS:  blank_nxt = {phase_nxt, phase_nxt, 2'b00};
            SET_MINS: blank_nxt = {2'b00, phase_nxt, phase_nxt};
            default:  blank_nxt = 4'b0000;
        endcase
    end

    always_ff @(posedge clk_100Mhz or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            mode        <= 2'd0;
            clk_pause   <= 1'b0;
            digit_blank <= 4'b0000;
            inc_hrs     <= 1'b0;
            inc_mins    <= 1'b0;
            phase       <= 1'b0;
            blink_cnt   <= '0;
            to_cnt      <= '0;
            hold_cnt    <= '0;
            armed       <= 1'b0;
            repeating   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode        <= state_nxt;
            clk_pause   <= (state_nxt != RUN);
            digit_blank <= blank_nxt;
            inc_hrs     <= pulse && (state == SET_HRS);
            inc_mins    <= pulse && (state == SET_MINS);
            phase       <= phase_nxt;

            if (state_nxt == RUN || entering || pulse || blink_cnt == BLINK_LAST) blink_cnt <= '0;
            else                                                                  blink_cnt <= blink_cnt + 1'b1;

            if (state_nxt == RUN || state_nxt != state || up_press || rpt_fire) to_cnt <= '0;
            else                                                                to_cnt <= to_cnt + 1'b1;

            // Repeat is armed only by an accepted press, so it never survives a mode change.
            if (state_nxt != state || !up_level) begin
                armed     <= 1'b0;
                repeating <= 1'b0;
                hold_cnt  <= '0;
            end else if (up_accept) begin
                armed     <= 1'b1;
                repeating <= 1'b0;
                hold_cnt  <= '0;
            end else if (rpt_fire) begin
                repeating <= 1'b1;
                hold_cnt  <= '0;
            end else if (armed) begin
                hold_cnt  <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Front-panel controller for the 7-segment digital clock: turns raw mode/up buttons into a RUN / SET_HRS / SET_MINS time-setting sequence.
- Drives single-cycle inc_hrs/inc_mins pulses, with auto-repeat while held, into the binary clock core.
- Pauses seconds counting during setting and produces a per-digit blank mask so the field being edited blinks on the display.

Parameters:
- DEBOUNCE_CYC, 1_000_000, cycles a synchronized button must be stable before its debounced level updates (10 ms @ 100 MHz)
- REPEAT_DELAY_CYC, 50_000_000, cycles btn_up must be held after the initial pulse before auto-repeat starts
- REPEAT_PERIOD_CYC, 20_000_000, cycles between auto-repeat pulses
- BLINK_HALF_CYC, 25_000_000, half-period of the edit-field blink
- TIMEOUT_CYC, 1_000_000_000, idle cycles in a SET state before returning to RUN; counter width $clog2(TIMEOUT_CYC+1)

Ports:
- clk_100Mhz  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- btn_mode  in  1  raw mode button, active-high, asynchronous to the clock
- btn_up  in  1  raw increment button, active-high, asynchronous to the clock
- inc_hrs  out  1  one-cycle pulse: increment hours
- inc_mins  out  1  one-cycle pulse: increment minutes
- clk_pause  out  1  1 while in SET_HRS or SET_MINS; clock core holds its seconds prescaler
- mode  out  2  0 = RUN, 1 = SET_HRS, 2 = SET_MINS (3 unused)
- digit_blank  out  4  1 = blank the digit; [3] hrs tens, [2] hrs ones, [1] mins tens, [0] mins ones

Behaviour:
- Reset (reset=0, asynchronous) clears everything:
  - state RUN
  - all outputs 0
  - synchronizers, debounced levels, all counters and blink phase cleared to 0
- Input synchronizer: 2-FF per button.
- Debounce:
  - Per-button counter, cleared whenever the synchronized level equals the debounced level.
  - When they differ, the counter increments. When it reaches DEBOUNCE_CYC-1, the debounced level takes the synchronized value and the counter clears.
  - A bounce shorter than DEBOUNCE_CYC produces no change.
- Press event: one-cycle, on a 0->1 transition of a debounced level (registered). A release generates nothing.
- FSM, evaluated on press events:
  - RUN: mode_press -> SET_HRS; up_press ignored.
  - SET_HRS: mode_press -> SET_MINS.
  - SET_MINS: mode_press -> RUN.
  - In SET_HRS / SET_MINS, timeout expiry -> RUN.
- Increment:
  - In SET_HRS, up_press gives inc_hrs=1 for exactly one cycle, the cycle after the press event. In SET_MINS, inc_mins likewise.
  - inc_hrs and inc_mins are never high in the same cycle and are never high in RUN.
- Auto-repeat:
  - While the debounced up level is 1 in a SET state, the hold counter counts from the initial pulse.
  - After REPEAT_DELAY_CYC cycles, one pulse is emitted; after that, one pulse every REPEAT_PERIOD_CYC cycles.
  - Debounced release, any state change, or reset clears the hold counter. Repeat never carries across a mode change.
- Simultaneous mode_press and up_press in one cycle: the mode transition wins, no inc pulse is emitted, and the repeat is disarmed until up is released and pressed again.
- Timeout:
  - The counter runs only in SET states and clears on every press event (mode or up) and on every repeat pulse.
  - On reaching TIMEOUT_CYC-1: state -> RUN next cycle, no inc pulse.
- Blink:
  - Phase toggles every BLINK_HALF_CYC cycles while in a SET state.
  - Phase resets to 0 (visible) on entry to any SET state and on every inc pulse, so an edited field is always shown right after it changes.
- digit_blank:
  - RUN: 4'b0000.
  - SET_HRS: {phase, phase, 2'b00}.
  - SET_MINS: {2'b00, phase, phase}.
- Outputs clk_pause, mode and digit_blank are registered and change on the cycle the state changes.
- Latency: a clean raw press gives the press event 2 (sync) + DEBOUNCE_CYC cycles later; inc pulse / state change 1 cycle after that.
- Reset asserted mid-press or mid-repeat aborts immediately; after release, a still-held button produces a press event only after a fresh debounce (debounced level restarts at 0).

Test Plan:
Bench parameters: DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_PERIOD_CYC=8, BLINK_HALF_CYC=10, TIMEOUT_CYC=100.
- Clean mode press (held 10 cycles) three times: mode 0->1->2->0. clk_pause=1 only in 1 and 2. Each change occurs 7 cycles after the raw rising edge. No inc pulses.
- btn_mode toggling every 2 cycles for 20 cycles, then low: no mode change, no press event.
- In SET_MINS, hold btn_up 60 cycles: inc_mins pulses at hold cycles 0, 20, 28, 36, 44, 52 (6 pulses, each 1 cycle wide); inc_hrs stays 0. After release, no further pulses.
- btn_up press in RUN: no inc pulses, mode stays 0. btn_mode and btn_up rising in the same cycle from RUN: mode=1, no inc_hrs; keep up held 40 cycles -> still no pulses.
- In SET_HRS with no presses: digit_blank alternates 4'b0000 / 4'b1100 every 10 cycles. An up press forces 4'b0000 for the next 10 cycles. With 100 idle cycles, mode returns to 0 and digit_blank=0.
- In SET_MINS while btn_up is held and repeating, assert reset for 3 cycles: all outputs 0 immediately (asynchronously). After release with up still high, mode stays 0 and no inc pulse occurs.
